// File: rtl/lrhls_mul_arbiter.sv
// Round-robin arbiter sharing one signed-18 x unsigned-13 multiplier among NREQ requesters.
// Latency: a grant in cycle c returns its product on rsp_* in cycle c+2 (S1 operand reg, S2 product reg).
// Backpressure: rsp_ready low stalls S2, then S1, then all grants; held data stays stable.
//
// Ports:
//   ap_clk, ap_rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester handshake (req_ready one-hot or zero)
//   req_a (NREQ*18), req_b (NREQ*13)  packed per-requester operands
//   rsp_valid/rsp_ready         product handshake; rsp_id tags the owner, rsp_p is the 31-bit product
//   busy                        any pipeline stage holds data
module lrhls_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*18-1:0]   req_a,
    input  logic [NREQ*13-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [30:0]          rsp_p,
    output logic                 busy
);

    // Pipeline state
    logic [IDW-1:0] rr_ptr_q;
    logic           s1_vld_q;
    logic [17:0]    s1_a_q;
    logic [12:0]    s1_b_q;
    logic [IDW-1:0] s1_id_q;
    logic           s2_vld_q;
    logic [30:0]    s2_p_q;
    logic [IDW-1:0] s2_id_q;

    logic           s1_en;
    logic           s2_en;
    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           take;
    logic [17:0]    sel_a;
    logic [12:0]    sel_b;
    logic [30:0]    prod;

    assign s2_en = !s2_vld_q || rsp_ready;
    assign s1_en = !s1_vld_q || s2_en;

    // Walk candidates from rr_ptr+1 with explicit wrap so non-power-of-two NREQ works.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (cand == IDW'(NREQ - 1)) begin
                cand = '0;
            end else begin
                cand = cand + 1'b1;
            end
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Reset gates the grant so nothing is accepted while the pipeline is held clear.
    assign take      = s1_en && grant_vld && ap_rst_n;
    assign req_ready = take ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[i*18 +: 18];
                sel_b = req_b[i*13 +: 13];
            end
        end
    end

    // Both operands widened to 31 bits; the exact product always fits, so the wrap is harmless.
    assign prod = $signed({{13{s1_a_q[17]}}, s1_a_q}) * $signed({18'b0, s1_b_q});

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr_q <= IDW'(NREQ - 1);
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_id_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_p_q   <= '0;
            s2_id_q  <= '0;
        end else begin
            if (s1_en) begin
                s1_vld_q <= take;
                if (take) begin
                    s1_a_q   <= sel_a;
                    s1_b_q   <= sel_b;
                    s1_id_q  <= grant_idx;
                    rr_ptr_q <= grant_idx;
                end
            end
            if (s2_en) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_p_q  <= prod;
                    s2_id_q <= s1_id_q;
                end
            end
        end
    end

    assign rsp_valid = s2_vld_q;
    assign rsp_p     = s2_p_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_vld_q || s2_vld_q;

endmodule

// File: tb/tb_lrhls_mul_arbiter.sv
module tb_lrhls_mul_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                ap_clk = 1'b0;
    logic                ap_rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*18-1:0]  req_a;
    logic [NREQ*13-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [30:0]         rsp_p;
    logic                busy;

    lrhls_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int id;
        int a;
        int b;
        int p;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*18 +: 18] = 18'(a);
        req_b[i*13 +: 13] = 13'(b);
    endtask

    function automatic longint p_val();
        return longint'($signed(rsp_p));
    endfunction

    initial begin
        vecs[0] = '{id: 2, a: -5,      b: 7,    p: -35};
        vecs[1] = '{id: 0, a: -131072, b: 8191, p: -1073610752};
        vecs[2] = '{id: 1, a: 131071,  b: 8191, p: 1073602561};
        vecs[3] = '{id: 3, a: -1,      b: 0,    p: 0};
        vecs[4] = '{id: 3, a: 100,     b: 4000, p: 400000};
        vecs[5] = '{id: 1, a: -1,      b: 8191, p: -8191};

        // Reset state, with requests already present
        ap_rst_n  = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_p", p_val(), 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_req_ready", req_ready, 0);
        @(negedge ap_clk);
        req_valid = '0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Single-request vectors
        for (int v = 0; v < 6; v++) begin
            @(negedge ap_clk);
            rsp_ready = 1'b1;
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            req_valid = NREQ'(1) << vecs[v].id;
            #1;
            chk("vec_req_ready", req_ready, longint'(NREQ'(1) << vecs[v].id));
            @(negedge ap_clk);
            req_valid = '0;
            #1;
            chk("vec_s1_only_valid", rsp_valid, 0);
            chk("vec_s1_busy", busy, 1);
            @(negedge ap_clk);
            #1;
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_id", rsp_id, vecs[v].id);
            chk("vec_rsp_p", p_val(), vecs[v].p);
            @(negedge ap_clk);
            #1;
            chk("vec_drained", busy, 0);
        end

        // Round robin after reset: all requesters continuously valid
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", req_ready, longint'(NREQ'(1) << (c % 4)));
            if (c >= 2) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_rsp_id", rsp_id, (c - 2) % 4);
                chk("rr_rsp_p", p_val(), ((c - 2) % 4 + 1) * 10);
            end
            @(negedge ap_clk);
        end
        req_valid = '0;
        repeat (2) @(negedge ap_clk);
        #1;
        chk("rr_drained", busy, 0);

        // Backpressure: three pending, rsp_ready low (rr_ptr = 3)
        @(negedge ap_clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_op(i, -3 * (i + 1), 5);
        req_valid = 4'b0111;
        #1;
        chk("bp_grant0", req_ready, 4'b0001);
        @(negedge ap_clk);
        req_valid = 4'b0110;
        #1;
        chk("bp_grant1", req_ready, 4'b0010);
        @(negedge ap_clk);
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_no_grant", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_id_hold", rsp_id, 0);
            chk("bp_rsp_p_hold", p_val(), -15);
            @(negedge ap_clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_grant2", req_ready, 4'b0100);
        chk("bp_rsp0_id", rsp_id, 0);
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        chk("bp_rsp1_valid", rsp_valid, 1);
        chk("bp_rsp1_id", rsp_id, 1);
        chk("bp_rsp1_p", p_val(), -30);
        @(negedge ap_clk);
        #1;
        chk("bp_rsp2_valid", rsp_valid, 1);
        chk("bp_rsp2_id", rsp_id, 2);
        chk("bp_rsp2_p", p_val(), -45);
        @(negedge ap_clk);
        #1;
        chk("bp_no_dup", rsp_valid, 0);
        chk("bp_drained", busy, 0);

        // Fairness with a gap: set rr_ptr = 1, then 1 and 3 both valid
        @(negedge ap_clk);
        set_op(1, 7, 3);
        set_op(3, -9, 2);
        req_valid = 4'b0010;
        #1;
        chk("gap_prime", req_ready, 4'b0010);
        @(negedge ap_clk);
        req_valid = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("gap_grant", req_ready, (c % 2 == 0) ? 4'b1000 : 4'b0010);
            if (c >= 2) begin
                chk("gap_rsp_id", rsp_id, (c % 2 == 0) ? 3 : 1);
                chk("gap_rsp_p", p_val(), (c % 2 == 0) ? -18 : 21);
            end
            @(negedge ap_clk);
        end
        req_valid = '0;
        repeat (2) @(negedge ap_clk);

        // Reset with both stages full (rr_ptr = 1, so 0 then 1 are granted)
        rsp_ready = 1'b0;
        set_op(0, 11, 2);
        set_op(1, 13, 3);
        req_valid = 4'b0011;
        #1;
        chk("mid_grant0", req_ready, 4'b0001);
        @(negedge ap_clk);
        req_valid = 4'b0010;
        #1;
        chk("mid_grant1", req_ready, 4'b0010);
        @(negedge ap_clk);
        req_valid = 4'b0011;
        #1;
        chk("mid_full_busy", busy, 1);
        chk("mid_full_valid", rsp_valid, 1);
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_p", p_val(), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_grant", req_ready, 4'b0001);
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        chk("post_rst_s1_valid", rsp_valid, 0);
        @(negedge ap_clk);
        #1;
        chk("post_rst_rsp_valid", rsp_valid, 1);
        chk("post_rst_rsp_id", rsp_id, 0);
        chk("post_rst_rsp_p", p_val(), 22);
        @(negedge ap_clk);
        #1;
        chk("post_rst_no_stale", rsp_valid, 0);
        chk("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lrhls_mul_arbiter.md
# lrhls_mul_arbiter

Round-robin arbiter and pipeline controller that shares one signed-18 × unsigned-13 multiplier (31-bit product) among NREQ requesters in the LRHLS linear-regression datapath. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the operands, multiplies, and returns the product tagged with the requester index through a backpressured response port. It sits between the per-stub residual/weight engines and the single shared DSP slice, which saves DSPs at 360 MHz.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, 2: response tag width, equal to clog2(NREQ).
- ap_clk  in  1  clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant/accept. This signal is one-hot or zero.
- req_a  in  NREQ*18  signed multiplicand. Requester i occupies bits [18i+17:18i].
- req_b  in  NREQ*13  unsigned multiplier. Requester i occupies bits [13i+12:13i].
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  downstream accepts product.
- rsp_id  out  IDW  index of the requester that owns rsp_p.
- rsp_p  out  31  signed product, sign-extended to exactly 31 bits.
- busy  out  1  high when any pipeline stage holds valid data.

## Operation
- Arithmetic: rsp_p = signed(a) × signed({1'b0,b}).
  - The result is exact in 31 bits: the range is -131072×8191 .. 131071×8191.
  - There is no rounding and no saturation.
- Pipeline has two stages, each with its own valid bit.
  - S1 is the operand register: a, b, id.
  - S2 is the product register, which drives the rsp_* outputs.
- Stage advance rules:
  - s2_en = !s2_valid || rsp_ready.
  - s1_en = !s1_valid || s2_en.
- Arbitration happens only when s1_en = 1.
  - Priority starts at rr_ptr+1 and wraps modulo NREQ.
  - The first asserted req_valid in that order wins.
  - req_ready[win] = 1 combinationally in the same cycle.
  - If s1_en = 0, req_ready is all zero.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i].
  - On transfer, S1 loads the operands and id = i, and rr_ptr <= i.
  - rr_ptr does not change on cycles without a grant.
- req_ready does not depend on req_valid of the same requester beyond arbitration. The requester must hold its operands and valid until it is granted.
- S1 to S2 transfer: when s1_en && s1_valid, S2 loads the product of the S1 operands and the S1 id. s2_valid follows s1_valid when s2_en.
- If S1 empties with no new grant, s1_valid <= 0.
- rsp_valid = s2_valid.
  - Once asserted, rsp_valid, rsp_p and rsp_id hold stable until rsp_ready.
- busy = s1_valid || s2_valid.

## Timing
- Reset values (asynchronous, on ap_rst_n = 0):
  - s1_valid = s2_valid = 0, so rsp_valid = 0 and busy = 0.
  - rsp_p = 0, rsp_id = 0.
  - rr_ptr = NREQ-1, so requester 0 has top priority first.
  - req_ready = 0 while reset is asserted.
- Reset deassertion is used synchronously internally (two-flop release is the top level's job). The first grant is possible on the first edge after release.
- Latency: grant at edge N, rsp_valid at edge N+2, i.e. visible after the second rising edge.
- Throughput: one product per cycle with rsp_ready held high.
- Full pipeline (S1 and S2 valid, rsp_ready = 0): no grants, and the state holds.
  - When rsp_ready rises, S2 drains, S1 moves to S2, and a new grant occurs in the same cycle.
- Simultaneous requests: strict rotation. Each requester waits at most NREQ-1 grants.
- Reset mid-operation: all in-flight products are dropped without a response. Requesters must reissue.
- Wrap-around: when rr_ptr = NREQ-1, priority starts at 0.
- The multiplier is a single combinational product between S1 and S2, registered at S2. It is mapped onto one DSP48E2 with the S1 register as the A/B registers and the S2 register as PREG.

## Test plan
- Single request: requester 2 presents a = -5, b = 7 with rsp_ready = 1 → req_ready = 0100 that cycle; two cycles later rsp_valid = 1, rsp_id = 2, rsp_p = -35.
- Extremes:
  - a = -131072, b = 8191 → rsp_p = -1073610752.
  - a = 131071, b = 8191 → rsp_p = 1073602561.
  - a = 0x3FFFF (= -1), b = 0 → rsp_p = 0.
- All four requesters valid continuously after reset → grant order 0,1,2,3,0,1…; rsp_id sequence matches; one response per cycle.
- Backpressure:
  - Hold rsp_ready = 0 with three requests pending → at most two accepted, req_ready = 0 thereafter, and rsp_p/rsp_id stable.
  - Release rsp_ready → remaining responses arrive in grant order with no loss or duplication.
- Fairness with a gap: requesters 1 and 3 valid, rr_ptr = 1 → 3 is granted, then 1, then 3, alternating.
- Reset asserted while S1 and S2 are valid → rsp_valid and busy drop immediately (asynchronously). After release, requester 0 has priority and no stale response appears.
